// File: rtl/spike_rate_encoder.sv
module spike_rate_encoder #(
  parameter int unsigned NUM_STEPS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_intensity,
  input  logic       step_en,
  input  logic       flush,
  output logic       spike_out,
  output logic [7:0] step_idx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  LAST_STEP = 8'(NUM_STEPS - 1);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic [7:0]  intensity;
  logic [7:0]  counter;

  always_comb begin
    lfsr_nx  = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    in_ready = (state == IDLE);
    busy     = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED;
      intensity  <= '0;
      counter    <= '0;
      spike_out  <= 1'b0;
      step_idx   <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      spike_out  <= 1'b0;
      counter    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      spike_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            intensity <= in_intensity;
            counter   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (step_en) begin
            lfsr      <= lfsr_nx;
            spike_out <= (lfsr_nx[7:0] < intensity);
            step_idx  <= counter;
            counter   <= counter + 8'd1;
            if (counter == LAST_STEP) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
